fifo_reader: RTL and testbench

FIFO_READER -- requirements
Module: fifo_reader

---
 rtl/fifo_reader.sv | 128 ++++++++++++
 tb/tb_fifo_reader.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_reader.sv
// rtl/fifo_reader.sv - burst reader draining a FIFO into a valid/ready output stream
module fifo_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_WIDTH-1:0]  count,
  input  logic                  fifo_empty,
  output logic                  fifo_rinc,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready
);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t                state, state_nxt;
  logic [LEN_WIDTH-1:0]  issue_left, out_left, count_q;
  logic [DATA_WIDTH-1:0] buf0, buf1;
  logic [1:0]            occ;
  logic                  in_flight;
  logic                  done_q;
  logic                  launch, zero_req, last_xfer, pop, rinc;
  logic [2:0]            pending;
  logic [2:0]            room_limit;

  // Next-state and burst-control decode
  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    zero_req  = 1'b0;
    last_xfer = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (len != '0) begin
            launch    = 1'b1;
            state_nxt = DRAIN;
          end else begin
            zero_req = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (pop && out_left == LEN_WIDTH'(1)) begin
          last_xfer = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Read issue: a slot freed by this cycle's pop is reused so the stream sustains one word per cycle
  always_comb begin
    pop        = (occ != 2'd0) & m_ready & ~rst;
    pending    = {1'b0, occ} + {2'b00, in_flight};
    room_limit = 3'd2 + {2'b00, pop};
    rinc       = (state == DRAIN) & ~fifo_empty & (issue_left != '0)
               & (pending < room_limit) & ~rst;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Burst counters, in-flight tracking and the 2-entry output buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_left <= '0;
      out_left   <= '0;
      count_q    <= '0;
      occ        <= 2'd0;
      in_flight  <= 1'b0;
      done_q     <= 1'b0;
      buf0       <= '0;
      buf1       <= '0;
    end else begin
      done_q    <= zero_req | last_xfer;
      in_flight <= rinc;
      if (launch) begin
        issue_left <= len;
        out_left   <= len;
        count_q    <= '0;
      end else begin
        if (rinc) issue_left <= issue_left - LEN_WIDTH'(1);
        if (pop) begin
          out_left <= out_left - LEN_WIDTH'(1);
          count_q  <= count_q + LEN_WIDTH'(1);
        end
      end
      if (in_flight && !pop) begin
        if (occ == 2'd0) buf0 <= fifo_rdata;
        else             buf1 <= fifo_rdata;
        occ <= occ + 2'd1;
      end else if (!in_flight && pop) begin
        buf0 <= buf1;
        occ  <= occ - 2'd1;
      end else if (in_flight && pop) begin
        if (occ == 2'd1) begin
          buf0 <= fifo_rdata;
        end else begin
          buf0 <= buf1;
          buf1 <= fifo_rdata;
        end
      end
    end
  end

  // Outputs forced quiet while reset is held
  always_comb begin
    busy      = (state == DRAIN) & ~rst;
    done      = done_q & ~rst;
    count     = count_q;
    fifo_rinc = rinc;
    m_valid   = (occ != 2'd0) & ~rst;
    m_data    = rst ? '0 : buf0;
  end

endmodule

// File: tb/tb_fifo_reader.sv
// tb/tb_fifo_reader.sv - scoreboard bench for fifo_reader
module tb_fifo_reader;
  localparam int DW = 8;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst, start, fifo_empty, m_ready;
  logic [LW-1:0] len;
  logic [DW-1:0] fifo_rdata;
  logic          busy, done, fifo_rinc, m_valid;
  logic [LW-1:0] count;
  logic [DW-1:0] m_data;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int rinc_cnt = 0;
  int done_cnt = 0;
  logic stall = 1'b0;
  logic rd_req = 1'b0;
  logic hold_prev = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic [DW-1:0] last_popped = '0;
  logic [DW-1:0] lp_rst;
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got_q[$];
  int xfer_cyc[$];

  fifo_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy), .done(done),
    .count(count), .fifo_empty(fifo_empty), .fifo_rinc(fifo_rinc),
    .fifo_rdata(fifo_rdata), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic upd_empty;
    fifo_empty = stall || (fifo_q.size() == 0);
  endtask

  task automatic load(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) fifo_q.push_back(base + DW'(i));
    upd_empty();
  endtask

  task automatic start_burst(input logic [LW-1:0] l);
    got_q.delete();
    xfer_cyc.delete();
    rinc_cnt = 0;
    done_cnt = 0;
    start = 1'b1;
    len = l;
    tick();
    start = 1'b0;
    len = '0;
  endtask

  task automatic wait_done(input string tag, input int max);
    int k = 0;
    while (!done && k < max) begin
      tick();
      k++;
    end
    check({tag, "_done_seen"}, done, 1);
    check({tag, "_idle_at_done"}, busy, 0);
    tick();
    check({tag, "_done_one_cycle"}, done, 0);
  endtask

  // FIFO read side: a strobe seen this cycle yields data just after the next edge
  always @(posedge clk) begin
    cyc++;
    #1;
    if (rd_req) begin
      rd_req = 1'b0;
      if (fifo_q.size() == 0) begin
        check("fifo_underflow", 1, 0);
      end else begin
        fifo_rdata = fifo_q.pop_front();
        last_popped = fifo_rdata;
        exp_q.push_back(fifo_rdata);
      end
    end else begin
      fifo_rdata = 8'hEE;
    end
    upd_empty();
  end

  // Mid-cycle monitor: read strobes, done pulses, transfers and hold stability
  always @(negedge clk) begin
    rd_req = fifo_rinc;
    if (fifo_rinc) begin
      rinc_cnt++;
      check("rinc_while_empty", fifo_empty, 0);
    end
    if (done) done_cnt++;
    if (!rst && hold_prev) begin
      check("hold_valid", m_valid, 1);
      check("hold_data", m_data, prev_data);
    end
    if (!rst && m_valid && m_ready) begin
      got_q.push_back(m_data);
      xfer_cyc.push_back(cyc);
      if (exp_q.size() == 0) check("sb_underrun", 1, 0);
      else check("sb_data", m_data, exp_q.pop_front());
    end
    hold_prev = !rst && m_valid && !m_ready;
    prev_data = m_data;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; m_ready = 1'b0;
    fifo_rdata = '0; fifo_empty = 1'b1;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rinc", fifo_rinc, 0);
    check("rst_valid", m_valid, 0);
    check("rst_data", m_data, 0);
    rst = 1'b0;
    tick();
    check("rst_count", count, 0);

    // Full-rate burst of four preloaded words
    load(4, 8'h11);
    m_ready = 1'b1;
    start_burst(8'd4);
    wait_done("t1", 40);
    check("t1_n", got_q.size(), 4);
    for (int i = 0; i < 4 && i < got_q.size(); i++) check("t1_word", got_q[i], 32'h11 + i);
    if (xfer_cyc.size() == 4) check("t1_back_to_back", xfer_cyc[3] - xfer_cyc[0], 3);
    check("t1_count", count, 4);
    check("t1_done_once", done_cnt, 1);

    // Downstream stall on the first word
    load(3, 8'h11);
    m_ready = 1'b0;
    start_burst(8'd3);
    begin
      int k = 0;
      while (!m_valid && k < 20) begin tick(); k++; end
    end
    check("t2_valid", m_valid, 1);
    for (int i = 0; i < 5; i++) begin
      check("t2_hold_word", m_data, 8'h11);
      tick();
    end
    check("t2_issues", rinc_cnt, 2);
    m_ready = 1'b1;
    wait_done("t2", 40);
    check("t2_n", got_q.size(), 3);
    for (int i = 0; i < 3 && i < got_q.size(); i++) check("t2_word", got_q[i], 32'h11 + i);
    check("t2_count", count, 3);

    // FIFO runs dry mid-burst
    load(5, 8'h21);
    start_burst(8'd5);
    tick();
    tick();
    stall = 1'b1;
    upd_empty();
    #1;
    for (int i = 0; i < 4; i++) begin
      check("t3_no_rinc", fifo_rinc, 0);
      check("t3_busy", busy, 1);
      tick();
    end
    stall = 1'b0;
    upd_empty();
    wait_done("t3", 60);
    check("t3_n", got_q.size(), 5);
    for (int i = 0; i < 5 && i < got_q.size(); i++) check("t3_word", got_q[i], 32'h21 + i);
    check("t3_count", count, 5);
    check("t3_done_once", done_cnt, 1);

    // Zero-length request with data waiting in the FIFO
    load(8, 8'h31);
    start_burst(8'd0);
    check("t4_done", done, 1);
    check("t4_busy", busy, 0);
    tick();
    check("t4_done_clear", done, 0);
    tick();
    check("t4_no_rinc", rinc_cnt, 0);

    // Reset after two of six words
    start_burst(8'd6);
    begin
      int k = 0;
      while (got_q.size() < 2 && k < 40) begin tick(); k++; end
    end
    check("t5_two_seen", got_q.size(), 2);
    rst = 1'b1;
    exp_q.delete();
    lp_rst = last_popped;
    tick();
    rst = 1'b0;
    check("t5_busy", busy, 0);
    check("t5_valid", m_valid, 0);
    check("t5_count", count, 0);
    start_burst(8'd2);
    wait_done("t5", 40);
    check("t5_n", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check("t5_resume", got_q[0], lp_rst + 8'd1);
      check("t5_order", got_q[1], lp_rst + 8'd2);
    end
    check("t5_count2", count, 2);

    // Start pulsed while draining is ignored
    load(4, 8'h41);
    start_burst(8'd3);
    tick();
    start = 1'b1;
    len = 8'd9;
    tick();
    start = 1'b0;
    len = '0;
    wait_done("t6", 40);
    repeat (4) tick();
    check("t6_n", got_q.size(), 3);
    check("t6_count", count, 3);
    check("t6_idle", busy, 0);
    check("t6_done_once", done_cnt, 1);
    check("sb_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
